tno_tnc_gen: RTL and testbench
==============================

// Module: tno_tnc_gen
// PURPOSE
//  Generates the TNO (observation-interval start) and TNC (cycle start) reset pulses
//  from the 1 us time base. It is the source end of the TNO/TNC timing interface that the
//  period-measurement logic consumes. TNC repeats every period_tnc us. TNO repeats every
//  tno_div TNC cycles, and each TNO is coincident with a TNC.
//  New settings are shadowed and take effect only on a TNO boundary.
// PARAMETERS
//  PULSE_W   4   high time of reset_TNO/reset_TNC, in 1 us ticks (>=1)
//  IDX_W    16   width of tno_div and tnc_index
// PORTS
//  clk         in   1      system clock
//  rst         in   1      synchronous reset, active-high
//  clk1us      in   1      1 us strobe/square wave, asynchronous to clk; its rising edge is the tick
//  en          in   1      generator enable (level)
//  period_tnc  in   32     TNC period in us (shadowed)
//  tno_div     in   IDX_W  TNC cycles per TNO (shadowed)
//  reset_TNO   out  1      TNO pulse
//  reset_TNC   out  1      TNC pulse
//  tnc_index   out  IDX_W  TNC number within current TNO, 0 at TNO
//  us_count    out  32     us elapsed in current TNC cycle
//  running     out  1      1 in RUN state
// BEHAVIOUR
//  - Tick: 3-bit shift register on clk1us; tick = (sh[2:1]==2'b01). It is a one-clk strobe.
//  - Reset: all outputs 0, state IDLE, shadows 0, shift register 0.
//  - Clamping at load: p = max(period_tnc,2); d = max(tno_div,1); w = min(PULSE_W, p-1).
//    Each pulse therefore drops for at least 1 us before the next one.
//  - FSM IDLE -> ARM: on en=1.
//  - FSM ARM -> RUN: on the first tick.
//    - That tick loads the shadows, clears us_count and tnc_index, and starts both the TNO and TNC pulses.
//  - RUN, each tick:
//    - If us_count==p-1: us_count<=0 and a TNC pulse starts.
//      - If tnc_index==d-1 as well: tnc_index<=0, a TNO pulse starts, and the shadows reload.
//      - Otherwise tnc_index increments.
//    - Otherwise us_count increments.
//  - RUN/ARM -> IDLE: when en=0, in the same clk. All outputs drop to 0 on the next clk and the counters clear.
//    A pulse in progress is truncated.
//  - Pulse timing: the output goes high on the clk after the boundary tick. It goes low on the clk after
//    the w-th following tick, giving exactly w us high.
//    - A width counter per output decrements on ticks.
//    - If a new boundary falls on the same tick as the fall, the new pulse wins and the width reloads.
//  - All outputs are registered. Latency from the tick edge on clk1us to the pulse is 3 clk.
//  - us_count and tnc_index never wrap past p-1 and d-1.
//  - Changes to period_tnc or tno_div mid-TNO are ignored until the next TNO boundary.
//  - rst mid-operation returns to IDLE within 1 clk. With en still high, the block re-arms and
//    restarts with TNO+TNC on the next tick.
// TESTING
//  1. period_tnc=1000, tno_div=4, en=1 -> TNC every 1000 us, TNO every 4000 us coincident with the
//     index-0 TNC; each pulse 4 us high; tnc_index cycles 0..3.
//  2. period_tnc changed from 1000 to 500 at tnc_index=1 -> the remaining TNCs in that TNO stay at
//     1000 us; 500 us applies from the next TNO.
//  3. period_tnc=1, tno_div=0 -> clamped to p=2, d=1; TNO=TNC every 2 us; width 1 us.
//  4. en dropped 2 us into a pulse -> reset_TNO/TNC low next clk; running=0; restart on en re-rise
//     begins with TNO at first tick.
//  5. rst asserted for 1 clk in mid-cycle with en=1 -> outputs 0; us_count=0; TNO+TNC restart on the
//     next tick.
//  6. clk1us jitter/phase sweep (clk1us asynchronous to clk) -> exactly one tick per clk1us rising edge;
//     no double counting.

Source files
------------

// File: rtl/tno_tnc_gen.sv
// tno_tnc_gen: TNO/TNC reset-pulse generator driven by the 1 us time base.
// Period/divider settings are shadowed and only reloaded on TNO boundaries.
module tno_tnc_gen #(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned IDX_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk1us,
    input  logic             en,
    input  logic [31:0]      period_tnc,
    input  logic [IDX_W-1:0] tno_div,
    output logic             reset_TNO,
    output logic             reset_TNC,
    output logic [IDX_W-1:0] tnc_index,
    output logic [31:0]      us_count,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

    localparam logic [31:0]      PW32    = 32'(PULSE_W);
    localparam logic [31:0]      ONE32   = 32'd1;
    localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       sh_q, sh_d;
    logic [31:0]      per_q, per_d;
    logic [31:0]      wid_q, wid_d;
    logic [IDX_W-1:0] div_q, div_d;
    logic [31:0]      us_q, us_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tno_q, tno_d;
    logic             tnc_q, tnc_d;
    logic [31:0]      tno_w_q, tno_w_d;
    logic [31:0]      tnc_w_q, tnc_w_d;
    logic             running_q, running_d;

    logic             tick;
    logic             clr;
    logic             load;
    logic             tno_start;
    logic             tnc_start;
    logic [31:0]      per_ld;
    logic [31:0]      wid_ld;
    logic [31:0]      wid_use;
    logic [IDX_W-1:0] div_ld;

    always_comb begin
        sh_d = {sh_q[1:0], clk1us};
        tick = (sh_q[2:1] == 2'b01);

        // Clamp so every pulse has at least 1 us low before the next one
        per_ld = (period_tnc < 32'd2) ? 32'd2 : period_tnc;
        div_ld = (tno_div == '0) ? ONE_IDX : tno_div;
        wid_ld = (PW32 < per_ld - ONE32) ? PW32 : per_ld - ONE32;

        state_d   = state_q;
        per_d     = per_q;
        wid_d     = wid_q;
        div_d     = div_q;
        us_d      = us_q;
        idx_d     = idx_q;
        tno_d     = tno_q;
        tnc_d     = tnc_q;
        tno_w_d   = tno_w_q;
        tnc_w_d   = tnc_w_q;
        clr       = 1'b0;
        load      = 1'b0;
        tno_start = 1'b0;
        tnc_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!en) begin
                    clr = 1'b1;
                end else if (tick) begin
                    state_d   = RUN;
                    load      = 1'b1;
                    tno_start = 1'b1;
                    tnc_start = 1'b1;
                    us_d      = '0;
                    idx_d     = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    clr = 1'b1;
                end else if (tick) begin
                    if (us_q == per_q - ONE32) begin
                        us_d      = '0;
                        tnc_start = 1'b1;
                        if (idx_q == div_q - ONE_IDX) begin
                            idx_d     = '0;
                            tno_start = 1'b1;
                            load      = 1'b1;
                        end else begin
                            idx_d = idx_q + ONE_IDX;
                        end
                    end else begin
                        us_d = us_q + ONE32;
                    end
                end
            end
            default: begin
                clr = 1'b1;
            end
        endcase

        if (load) begin
            per_d = per_ld;
            div_d = div_ld;
            wid_d = wid_ld;
        end
        wid_use = load ? wid_ld : wid_q;

        // A new boundary on the falling tick restarts the pulse
        if (tno_start) begin
            tno_d   = 1'b1;
            tno_w_d = wid_use;
        end else if (tno_q && tick) begin
            if (tno_w_q == ONE32) begin
                tno_d   = 1'b0;
                tno_w_d = '0;
            end else begin
                tno_w_d = tno_w_q - ONE32;
            end
        end

        if (tnc_start) begin
            tnc_d   = 1'b1;
            tnc_w_d = wid_use;
        end else if (tnc_q && tick) begin
            if (tnc_w_q == ONE32) begin
                tnc_d   = 1'b0;
                tnc_w_d = '0;
            end else begin
                tnc_w_d = tnc_w_q - ONE32;
            end
        end

        if (clr) begin
            state_d = IDLE;
            us_d    = '0;
            idx_d   = '0;
            tno_d   = 1'b0;
            tnc_d   = 1'b0;
            tno_w_d = '0;
            tnc_w_d = '0;
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            per_q     <= '0;
            wid_q     <= '0;
            div_q     <= '0;
            us_q      <= '0;
            idx_q     <= '0;
            tno_q     <= 1'b0;
            tnc_q     <= 1'b0;
            tno_w_q   <= '0;
            tnc_w_q   <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            per_q     <= per_d;
            wid_q     <= wid_d;
            div_q     <= div_d;
            us_q      <= us_d;
            idx_q     <= idx_d;
            tno_q     <= tno_d;
            tnc_q     <= tnc_d;
            tno_w_q   <= tno_w_d;
            tnc_w_q   <= tnc_w_d;
            running_q <= running_d;
        end
    end

    assign reset_TNO = tno_q;
    assign reset_TNC = tnc_q;
    assign tnc_index = idx_q;
    assign us_count  = us_q;
    assign running   = running_q;

endmodule

// File: tb/tb_tno_tnc_gen.sv
// tb_tno_tnc_gen: directed and randomized checks of tno_tnc_gen against
// a tick-level reference model (time within TNO -> expected outputs).
module tb_tno_tnc_gen;

    localparam int PW = 4;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk1us;
    logic          en;
    logic [31:0]   period_tnc;
    logic [IW-1:0] tno_div;
    logic          reset_TNO;
    logic          reset_TNC;
    logic [IW-1:0] tnc_index;
    logic [31:0]   us_count;
    logic          running;

    tno_tnc_gen #(
        .PULSE_W(PW),
        .IDX_W  (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk1us    (clk1us),
        .en        (en),
        .period_tnc(period_tnc),
        .tno_div   (tno_div),
        .reset_TNO (reset_TNO),
        .reset_TNC (reset_TNC),
        .tnc_index (tnc_index),
        .us_count  (us_count),
        .running   (running)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: m_t is us elapsed since the current TNO started
    bit     m_armed;
    bit     m_started;
    longint m_t;
    longint m_p;
    longint m_d;
    longint m_w;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_load();
        m_p = (period_tnc < 2) ? 2 : longint'(period_tnc);
        m_d = (tno_div == 0) ? 1 : longint'(tno_div);
        m_w = (PW < m_p - 1) ? PW : m_p - 1;
    endtask

    task automatic model_tick();
        if (m_started) begin
            m_t++;
            if (m_t == m_p * m_d) begin
                m_t = 0;
                model_load();
            end
        end else if (m_armed) begin
            m_started = 1'b1;
            m_t       = 0;
            model_load();
        end
    endtask

    task automatic check_all();
        longint e_us;
        longint e_idx;
        longint e_tnc;
        longint e_tno;
        longint e_run;
        e_us  = 0;
        e_idx = 0;
        e_tnc = 0;
        e_tno = 0;
        e_run = 0;
        if (m_started) begin
            e_us  = m_t % m_p;
            e_idx = m_t / m_p;
            e_tnc = (e_us < m_w) ? 1 : 0;
            e_tno = (m_t < m_w) ? 1 : 0;
            e_run = 1;
        end
        chk("us_count", 64'(us_count), 64'(e_us));
        chk("tnc_index", 64'(tnc_index), 64'(e_idx));
        chk("reset_TNC", 64'(reset_TNC), 64'(e_tnc));
        chk("reset_TNO", 64'(reset_TNO), 64'(e_tno));
        chk("running", 64'(running), 64'(e_run));
    endtask

    // Entered and left at posedge+1; rising edge lands at a random phase
    task automatic tick();
        int r;
        r = $urandom_range(10, 29);
        if (r % 10 == 9) r++;
        #(r);
        clk1us = 1'b1;
        model_tick();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        clk1us = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_en(input logic v);
        en      = v;
        m_armed = v;
        if (!v) m_started = 1'b0;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst        = 1'b1;
        clk1us     = 1'b0;
        en         = 1'b0;
        period_tnc = 32'd1000;
        tno_div    = 16'd4;
        m_armed    = 1'b0;
        m_started  = 1'b0;
        m_t        = 0;
        m_p        = 2;
        m_d        = 1;
        m_w        = 1;
        repeat (4) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all();

        // Nominal 1000 us x 4, then period change at tnc_index 1
        set_en(1'b1);
        ticks(5001);
        chk("idx_at_change", 64'(tnc_index), 64'd1);
        period_tnc = 32'd500;
        ticks(3000);
        chk("tno_after_change", 64'(reset_TNO), 64'd1);
        ticks(1002);
        chk("p500_index", 64'(tnc_index), 64'd2);

        // en dropped mid-pulse, then clamped settings on restart
        set_en(1'b0);
        chk("drop_tnc", 64'(reset_TNC), 64'd0);
        period_tnc = 32'd1;
        tno_div    = 16'd0;
        set_en(1'b1);
        ticks(12);

        // Synchronous reset for one clk mid-cycle with en held
        set_en(1'b0);
        period_tnc = 32'd7;
        tno_div    = 16'd3;
        set_en(1'b1);
        ticks(10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        m_started = 1'b0;
        check_all();
        chk("rst_us", 64'(us_count), 64'd0);
        ticks(25);

        // Randomized settings with ignored mid-TNO changes
        for (int k = 0; k < 8; k++) begin
            set_en(1'b0);
            period_tnc = 32'($urandom_range(0, 9));
            tno_div    = 16'($urandom_range(0, 4));
            set_en(1'b1);
            for (int j = 0; j < int'($urandom_range(20, 60)); j++) begin
                if ($urandom_range(0, 7) == 0)
                    period_tnc = 32'($urandom_range(0, 9));
                if ($urandom_range(0, 7) == 0)
                    tno_div = 16'($urandom_range(0, 4));
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
